// File: rtl/mm2im_pkg.sv
// Shared definitions for the mm2im output path: omap entry layout, FSM states
// and field extractors.
package mm2im_pkg;

   localparam int OMAP_W = 14;
   localparam int BANK_W = 4;
   localparam int ADDR_W = 10;

   // Mapper marker for "no destination"; cmap still decides whether a column is written.
   localparam logic [OMAP_W-1:0] OMAP_INVALID = 14'h3FFF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   function automatic logic [BANK_W-1:0] omap_bank(input logic [OMAP_W-1:0] e);
      return e[OMAP_W-1 -: BANK_W];
   endfunction

   function automatic logic [ADDR_W-1:0] omap_addr(input logic [OMAP_W-1:0] e);
      return e[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/mm2im_sat_add.sv
// Signed accumulate: sign-extends psum, adds at ACC_W+1 bits and clamps to the
// ACC_W signed range. ovf is high whenever a clamp was applied.
module mm2im_sat_add #(
   parameter int PSUM_W = 16,
   parameter int ACC_W  = 24
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PSUM_W-1:0] psum,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] wide;

   // One guard bit: the top two bits disagree exactly when the result left range.
   always_comb begin
      wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PSUM_W){psum[PSUM_W-1]}}, psum};
      ovf  = wide[ACC_W] ^ wide[ACC_W-1];
      sum  = wide[ACC_W-1:0];
      if (ovf)
         sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end

endmodule

// File: rtl/mm2im_out_accumulator.sv
// Serialises one mapper snapshot (NUM_PE columns) into read-modify-write cycles
// on the banked output BRAM. Read in cycle c, write in c+1; a read that hits the
// address being written in the same cycle takes the written value instead of
// the stale BRAM data. Fixed 18-cycle latency from acceptance to done.
module mm2im_out_accumulator
   import mm2im_pkg::*;
#(
   parameter int NUM_PE = 16,
   parameter int PSUM_W = 16,
   parameter int ACC_W  = 24
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       init,
   input  logic [NUM_PE-1:0]          cmap,
   input  logic [NUM_PE*OMAP_W-1:0]   omap_flat,
   input  logic [NUM_PE*PSUM_W-1:0]   psum_flat,
   output logic                       in_ready,
   output logic                       rd_en,
   output logic [BANK_W-1:0]          rd_bank,
   output logic [ADDR_W-1:0]          rd_addr,
   input  logic [ACC_W-1:0]           rd_data,
   output logic                       wr_en,
   output logic [BANK_W-1:0]          wr_bank,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [ACC_W-1:0]           wr_data,
   output logic                       done,
   output logic                       sat_flag
);

   localparam int IDX_W = $clog2(NUM_PE);

   state_t state, state_nxt;
   logic [IDX_W-1:0] idx;

   // snapshot captured at acceptance
   logic [NUM_PE-1:0]             cmap_q;
   logic [NUM_PE-1:0][OMAP_W-1:0] omap_q;
   logic [NUM_PE-1:0][PSUM_W-1:0] psum_q;
   logic                          init_q;

   // read stage (current column)
   logic              col_act, fwd_hit;
   logic [BANK_W-1:0] cur_bank;
   logic [ADDR_W-1:0] cur_addr;

   // write stage (column read one cycle earlier)
   logic              w_vld, w_init, w_fwd;
   logic [BANK_W-1:0] w_bank;
   logic [ADDR_W-1:0] w_addr;
   logic [PSUM_W-1:0] w_psum;
   logic [ACC_W-1:0]  w_fwd_data;

   logic [ACC_W-1:0]  acc_in, sum_sat, psum_ext;
   logic              ovf;

   // Next-state and ready; the timeline is fixed so only idx steers RUN->DRAIN.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (start) state_nxt = RUN;
         end
         RUN:     if (idx == IDX_W'(NUM_PE-1)) state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Read stage: decode the current column and detect a same-cycle write hit.
   always_comb begin
      col_act  = (state == RUN) && cmap_q[idx];
      cur_bank = omap_bank(omap_q[idx]);
      cur_addr = omap_addr(omap_q[idx]);
      rd_en    = col_act && !init_q;
      rd_bank  = rd_en ? cur_bank : '0;
      rd_addr  = rd_en ? cur_addr : '0;
      fwd_hit  = rd_en && w_vld && (cur_bank == w_bank) && (cur_addr == w_addr);
   end

   assign acc_in   = w_fwd ? w_fwd_data : rd_data;
   assign psum_ext = {{(ACC_W-PSUM_W){w_psum[PSUM_W-1]}}, w_psum};

   mm2im_sat_add #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_sat_add (
      .acc  (acc_in),
      .psum (w_psum),
      .sum  (sum_sat),
      .ovf  (ovf)
   );

   // Write stage outputs; everything reads zero while the stage is empty.
   always_comb begin
      wr_en   = w_vld;
      wr_bank = w_vld ? w_bank : '0;
      wr_addr = w_vld ? w_addr : '0;
      wr_data = '0;
      if (w_vld) wr_data = w_init ? psum_ext : sum_sat;
   end

   // Control state: FSM, column counter, write-stage valid, done and sticky saturation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         w_vld    <= 1'b0;
         done     <= 1'b0;
         sat_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= (state == RUN) ? idx + IDX_W'(1) : '0;
         w_vld <= col_act;
         done  <= (state == DRAIN);
         if (w_vld && !w_init && ovf) sat_flag <= 1'b1;
      end
   end

   // Datapath registers: snapshot capture and the read->write pipeline payload.
   always_ff @(posedge clk) begin
      if (start && in_ready) begin
         cmap_q <= cmap;
         omap_q <= omap_flat;
         psum_q <= psum_flat;
         init_q <= init;
      end
      w_bank     <= cur_bank;
      w_addr     <= cur_addr;
      w_psum     <= psum_q[idx];
      w_init     <= init_q;
      w_fwd      <= fwd_hit;
      w_fwd_data <= wr_data;
   end

endmodule

// File: tb/tb_mm2im_out_accumulator.sv
// Bench for mm2im_out_accumulator: BRAM model with 1-cycle read latency and
// old-data read-during-write, plus a column-by-column reference of the BRAM
// contents, expected write values and the sticky saturation flag.
module tb_mm2im_out_accumulator;

   localparam int NUM_PE = 16;
   localparam int PSUM_W = 16;
   localparam int ACC_W  = 24;
   localparam int MEM_N  = 16384;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, init = 1'b0;
   logic [NUM_PE-1:0]        cmap = '0;
   logic [NUM_PE*14-1:0]     omap_flat = '0;
   logic [NUM_PE*PSUM_W-1:0] psum_flat = '0;
   logic in_ready, rd_en, wr_en, done, sat_flag;
   logic [3:0] rd_bank, wr_bank;
   logic [9:0] rd_addr, wr_addr;
   logic [ACC_W-1:0] rd_data = '0, wr_data;

   logic [ACC_W-1:0] mem     [MEM_N];
   logic [ACC_W-1:0] ref_mem [MEM_N];
   logic [ACC_W-1:0] exp_val [NUM_PE];
   logic mem_clr_done = 1'b0;
   logic pl_en = 1'b0;
   logic [13:0] pl_a = '0;
   logic [ACC_W-1:0] pl_d = '0;
   logic ref_sat = 1'b0;
   int n_cmp = 0, n_bad = 0;

   mm2im_out_accumulator #(.NUM_PE(NUM_PE), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .init(init), .cmap(cmap),
      .omap_flat(omap_flat), .psum_flat(psum_flat), .in_ready(in_ready),
      .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
      .done(done), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   // BRAM model: cleared on the first edge, then read/write/preload ports.
   always @(posedge clk) begin
      if (!mem_clr_done) begin
         for (int a = 0; a < MEM_N; a++) mem[a] <= '0;
         mem_clr_done <= 1'b1;
      end else begin
         if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
         if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
         if (pl_en) mem[pl_a] <= pl_d;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [ACC_W-1:0] sat_ref(input logic [ACC_W-1:0] a,
                                                input logic [PSUM_W-1:0] p,
                                                output logic o);
      int s;
      s = int'($signed(a)) + int'($signed(p));
      o = 1'b0;
      if (s > 8388607) begin o = 1'b1; return 24'h7FFFFF; end
      if (s < -8388608) begin o = 1'b1; return 24'h800000; end
      return s[ACC_W-1:0];
   endfunction

   task automatic preload(input logic [13:0] a, input logic [ACC_W-1:0] d);
      pl_en = 1'b1; pl_a = a; pl_d = d;
      @(posedge clk); @(negedge clk);
      pl_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic check_mem(input string tag);
      int nd, first;
      nd = 0; first = -1;
      for (int a = 0; a < MEM_N; a++)
         if (mem[a] !== ref_mem[a]) begin
            nd++;
            if (first < 0) first = a;
         end
      n_cmp++;
      if (nd != 0) begin
         n_bad++;
         $display("FAIL %s bram: %0d words differ, first at %h got %h want %h",
                  tag, nd, first, mem[first], ref_mem[first]);
      end
   endtask

   // Starts at a negedge with the DUT idle (or in its done cycle); ends at the
   // negedge of cycle 18, or of cycle abort_at with rst_n driven low.
   task automatic run_snapshot(input string tag, input logic ini, input logic [15:0] cm,
                               input logic [15:0][13:0] om, input logic [15:0][15:0] ps,
                               input int abort_at);
      int limit;
      logic o, exp_rd, exp_wr;
      logic [ACC_W-1:0] v;
      limit = (abort_at > 0) ? abort_at : 17;
      for (int i = 0; i < NUM_PE; i++) begin
         exp_val[i] = '0;
         if (cm[i] && om[i] == 14'h3FFF)
            $display("note: %s column %0d has cmap=1 with an invalid omap entry (mapper bug)", tag, i);
         if (cm[i] && i + 2 <= limit) begin
            if (ini) v = {{8{ps[i][15]}}, ps[i]};
            else begin
               v = sat_ref(ref_mem[om[i]], ps[i], o);
               if (o) ref_sat = 1'b1;
            end
            ref_mem[om[i]] = v;
            exp_val[i] = v;
         end
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL %s accept: in_ready got %b want 1", tag, in_ready);
      end
      start = 1'b1; init = ini; cmap = cm; omap_flat = om; psum_flat = ps;
      for (int c = 1; c <= 18; c++) begin
         @(posedge clk); @(negedge clk);
         if (c == 1) begin
            start = 1'b0; init = $urandom; cmap = 16'($urandom);
            omap_flat = {7{$urandom}}; psum_flat = {8{$urandom}};
         end
         exp_rd = 1'b0;
         if (c <= 16) exp_rd = cm[c-1] & ~ini;
         exp_wr = 1'b0;
         if (c >= 2 && c <= 17) exp_wr = cm[c-2];
         n_cmp++;
         if (rd_en !== exp_rd) begin
            n_bad++; $display("FAIL %s c%0d rd_en got %b want %b", tag, c, rd_en, exp_rd);
         end
         if (exp_rd) begin
            n_cmp++;
            if ({rd_bank, rd_addr} !== om[c-1]) begin
               n_bad++; $display("FAIL %s c%0d rd_loc got %h want %h", tag, c, {rd_bank, rd_addr}, om[c-1]);
            end
         end
         n_cmp++;
         if (wr_en !== exp_wr) begin
            n_bad++; $display("FAIL %s c%0d wr_en got %b want %b", tag, c, wr_en, exp_wr);
         end
         if (exp_wr) begin
            n_cmp++;
            if ({wr_bank, wr_addr} !== om[c-2] || wr_data !== exp_val[c-2]) begin
               n_bad++;
               $display("FAIL %s c%0d write got %h:%h want %h:%h", tag, c,
                        {wr_bank, wr_addr}, wr_data, om[c-2], exp_val[c-2]);
            end
         end
         n_cmp++;
         if (done !== (c == 18) || in_ready !== (c == 18)) begin
            n_bad++; $display("FAIL %s c%0d done/in_ready got %b%b want %b%b", tag, c,
                              done, in_ready, c == 18, c == 18);
         end
         if (c == abort_at) begin
            rst_n = 1'b0;
            break;
         end
      end
      if (abort_at == 0) begin
         n_cmp++;
         if (sat_flag !== ref_sat) begin
            n_bad++; $display("FAIL %s sat_flag got %b want %b", tag, sat_flag, ref_sat);
         end
      end
   endtask

   task automatic test_reset();
      for (int a = 0; a < MEM_N; a++) ref_mem[a] = '0;
      ref_sat = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || rd_en !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0 || sat_flag !== 1'b0) begin
         n_bad++; $display("FAIL reset ctrl got rdy=%b rd=%b wr=%b done=%b sat=%b want 1 0 0 0 0",
                           in_ready, rd_en, wr_en, done, sat_flag);
      end
      n_cmp++;
      if ({rd_bank, rd_addr, wr_bank, wr_addr, wr_data} !== '0) begin
         n_bad++; $display("FAIL reset data got %h want 0", {rd_bank, rd_addr, wr_bank, wr_addr, wr_data});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_init_overwrite();
      logic [15:0][13:0] om;
      logic [15:0][15:0] ps;
      for (int i = 0; i < NUM_PE; i++) begin
         om[i] = {4'(i), 10'(i)};
         ps[i] = 16'(i - 8);
      end
      run_snapshot("init", 1'b1, 16'hFFFF, om, ps, 0);
      check_mem("init");
      @(negedge clk);
   endtask

   task automatic test_accumulate();
      logic [15:0][13:0] om;
      logic [15:0][15:0] ps;
      for (int i = 0; i < NUM_PE; i++) begin
         om[i] = {4'(i), 10'(i)};
         ps[i] = 16'd100;
      end
      run_snapshot("accum", 1'b0, 16'hFFFF, om, ps, 0);
      check_mem("accum");
      @(negedge clk);
   endtask

   task automatic test_sparse();
      logic [15:0][13:0] om;
      logic [15:0][15:0] ps;
      for (int i = 0; i < NUM_PE; i++) begin
         om[i] = {4'(i), 10'(i)};
         ps[i] = 16'($urandom);
      end
      run_snapshot("sparse", 1'b0, 16'h00F0, om, ps, 0);
      check_mem("sparse");
      @(negedge clk);
   endtask

   task automatic test_saturation();
      logic [15:0][13:0] om;
      logic [15:0][15:0] ps;
      for (int i = 0; i < NUM_PE; i++) begin
         om[i] = 14'(16'($urandom));
         ps[i] = 16'($urandom);
      end
      om[0] = {4'd1, 10'd100};
      om[1] = {4'd2, 10'd200};
      preload(om[0], 24'h7FFFF0);
      preload(om[1], 24'h800010);
      ps[0] = 16'sd15; ps[1] = -16'sd16;
      run_snapshot("sat_exact", 1'b0, 16'h0003, om, ps, 0);
      n_cmp++;
      if (mem[om[0]] !== 24'h7FFFFF || mem[om[1]] !== 24'h800000 || sat_flag !== 1'b0) begin
         n_bad++; $display("FAIL sat_exact got %h %h sat=%b want 7fffff 800000 sat=0",
                           mem[om[0]], mem[om[1]], sat_flag);
      end
      @(negedge clk);
      preload(om[0], 24'h7FFFF0);
      preload(om[1], 24'h800010);
      ps[0] = 16'sd32; ps[1] = -16'sd32;
      run_snapshot("sat_clamp", 1'b0, 16'h0003, om, ps, 0);
      n_cmp++;
      if (mem[om[0]] !== 24'h7FFFFF || mem[om[1]] !== 24'h800000 || sat_flag !== 1'b1) begin
         n_bad++; $display("FAIL sat_clamp got %h %h sat=%b want 7fffff 800000 sat=1",
                           mem[om[0]], mem[om[1]], sat_flag);
      end
      check_mem("sat");
      @(negedge clk);
   endtask

   task automatic test_forward_back_to_back();
      logic [15:0][13:0] om;
      logic [15:0][15:0] ps;
      for (int i = 0; i < NUM_PE; i++) begin
         om[i] = 14'(16'($urandom));
         ps[i] = 16'($urandom);
      end
      om[0] = {4'd3, 10'd5};
      om[1] = {4'd3, 10'd5};
      preload(om[0], 24'd10);
      ps[0] = 16'd1; ps[1] = 16'd2;
      run_snapshot("fwd", 1'b0, 16'h0003, om, ps, 0);
      n_cmp++;
      if (mem[{4'd3, 10'd5}] !== 24'd13) begin
         n_bad++; $display("FAIL fwd word got %0d want 13", mem[{4'd3, 10'd5}]);
      end
      ps[0] = 16'd5; ps[1] = 16'hFFFF;
      run_snapshot("b2b", 1'b0, 16'h0003, om, ps, 0);
      n_cmp++;
      if (mem[{4'd3, 10'd5}] !== 24'd17) begin
         n_bad++; $display("FAIL b2b word got %0d want 17", mem[{4'd3, 10'd5}]);
      end
      check_mem("fwd_b2b");
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [15:0][13:0] om;
      logic [15:0][15:0] ps;
      for (int k = 0; k < 8; k++)
         preload({4'(k % 4), 10'(k)}, k[0] ? 24'h7FF000 + 24'($urandom_range(0, 4095))
                                           : 24'h800000 + 24'($urandom_range(0, 4095)));
      for (int s = 0; s < 10; s++) begin
         for (int i = 0; i < NUM_PE; i++) begin
            om[i] = {4'($urandom_range(0, 3)), 10'($urandom_range(0, 7))};
            if ($urandom_range(0, 39) == 0) om[i] = 14'h3FFF;
            ps[i] = 16'($urandom);
         end
         run_snapshot("rand", ($urandom_range(0, 3) == 0), 16'($urandom), om, ps, 0);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      check_mem("rand");
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      logic [15:0][13:0] om;
      logic [15:0][15:0] ps;
      int seen_done;
      for (int i = 0; i < NUM_PE; i++) begin
         om[i] = {4'(i), 10'(i + 32)};
         ps[i] = 16'($urandom);
      end
      run_snapshot("abort", 1'b0, 16'hFFFF, om, ps, 8);
      ref_sat = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (rd_en !== 1'b0 || wr_en !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || sat_flag !== 1'b0) begin
         n_bad++; $display("FAIL abort state got rd=%b wr=%b rdy=%b done=%b sat=%b want 0 0 1 0 0",
                           rd_en, wr_en, in_ready, done, sat_flag);
      end
      rst_n = 1'b1;
      seen_done = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done === 1'b1 || wr_en === 1'b1) seen_done++;
      end
      n_cmp++;
      if (seen_done != 0) begin
         n_bad++; $display("FAIL abort quiet: %0d cycles with done/wr_en got want 0", seen_done);
      end
      check_mem("abort");
      for (int i = 0; i < NUM_PE; i++) ps[i] = 16'($urandom);
      run_snapshot("after_abort", 1'b0, 16'($urandom), om, ps, 0);
      check_mem("after_abort");
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_init_overwrite();
      test_accumulate();
      test_sparse();
      test_saturation();
      test_forward_back_to_back();
      test_random();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
